// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - state encoding, segment glyphs and one-hot decode shared by the quadrant display
package display_pkg;

    typedef enum logic [1:0] {
        VAZIO  = 2'd0,
        MOSTRA = 2'd1,
        ERRO   = 2'd2
    } estado_t;

    localparam int N_QUAD_MAX = 9;

    // Active-low glyphs, bits g..a
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Entry 0 is the dash so an empty digit register decodes to it
    localparam logic [9:0][6:0] GLYPH_DIGITO = {
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        GLYPH_DASH
    };

    // Returns quadrant index+1 for exactly one set bit, 0 for zero or several
    function automatic logic [3:0] onehot_digito(input logic [N_QUAD_MAX-1:0] v);
        logic [3:0] dig;
        int         n;
        dig = 4'd0;
        n   = 0;
        for (int i = 0; i < N_QUAD_MAX; i++) begin
            if (v[i]) begin
                n++;
                dig = 4'(i + 1);
            end
        end
        return (n == 1) ? dig : 4'd0;
    endfunction

endpackage

// File: rtl/hexa7seg_digito.sv
// rtl/hexa7seg_digito.sv - maps a stored digit to its active-low seven-segment glyph
module hexa7seg_digito
    import display_pkg::*;
(
    input  logic [3:0] digito,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        if (digito <= 4'd9) begin
            glyph = GLYPH_DIGITO[digito];
        end
    end

endmodule

// File: rtl/display_quadrante_pisca.sv
// rtl/display_quadrante_pisca.sv - registered one-hot quadrant display with blink, blank and timed error
module display_quadrante_pisca
    import display_pkg::*;
#(
    parameter int N_QUAD         = 9,
    parameter int BLINK_CYCLES   = 25000000,
    parameter int ERR_CYCLES     = 50000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              limpa,
    input  logic              carrega,
    input  logic [N_QUAD-1:0] quadrante,
    input  logic              pisca_en,
    input  logic              apaga,
    output logic [6:0]        display,
    output logic [3:0]        digito,
    output logic              valido,
    output logic              erro
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int EW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_CYCLES - 1);
    localparam logic [6:0]    POLARIDADE = SEG_ACTIVE_LOW ? 7'b0000000 : 7'b1111111;

    estado_t                 estado, estado_n;
    logic [3:0]              digito_n;
    logic                    valido_n;
    logic [BW-1:0]           bcnt, bcnt_n;
    logic                    fase, fase_n;
    logic [EW-1:0]           ecnt, ecnt_n;
    logic [6:0]              seg_n;
    logic [6:0]              glyph_n;
    logic [N_QUAD_MAX-1:0]   quad_ext;
    logic [3:0]              digito_carga;

    assign quad_ext     = N_QUAD_MAX'(quadrante);
    assign digito_carga = onehot_digito(quad_ext);
    assign erro         = (estado == ERRO);

    hexa7seg_digito u_hexa7seg (
        .digito (digito_n),
        .glyph  (glyph_n)
    );

    always_comb begin
        estado_n = estado;
        digito_n = digito;
        valido_n = valido;
        ecnt_n   = ecnt;
        if (bcnt == BLINK_LAST) begin
            bcnt_n = '0;
            fase_n = ~fase;
        end else begin
            bcnt_n = bcnt + 1'b1;
            fase_n = fase;
        end

        if (limpa) begin
            estado_n = VAZIO;
            digito_n = 4'd0;
            valido_n = 1'b0;
            bcnt_n   = '0;
            fase_n   = 1'b1;
            ecnt_n   = '0;
        end else if (carrega) begin
            bcnt_n = '0;
            fase_n = 1'b1;
            if (digito_carga != 4'd0) begin
                estado_n = MOSTRA;
                digito_n = digito_carga;
                valido_n = 1'b1;
            end else begin
                estado_n = ERRO;
                ecnt_n   = '0;
            end
        end else if (estado == ERRO) begin
            if (ecnt == ERR_LAST) begin
                ecnt_n   = '0;
                estado_n = valido ? MOSTRA : VAZIO;
            end else begin
                ecnt_n = ecnt + 1'b1;
            end
        end

        // Display is chosen from next-cycle state so it moves together with digito/erro
        if (limpa) begin
            seg_n = GLYPH_DASH;
        end else if (apaga) begin
            seg_n = GLYPH_BLANK;
        end else if (estado_n == ERRO && !fase_n) begin
            seg_n = GLYPH_BLANK;
        end else if (estado_n == MOSTRA && pisca_en && !fase_n) begin
            seg_n = GLYPH_BLANK;
        end else if (estado_n == MOSTRA) begin
            seg_n = glyph_n;
        end else begin
            seg_n = GLYPH_DASH;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= VAZIO;
            digito  <= 4'd0;
            valido  <= 1'b0;
            bcnt    <= '0;
            fase    <= 1'b1;
            ecnt    <= '0;
            display <= GLYPH_DASH ^ POLARIDADE;
        end else begin
            estado  <= estado_n;
            digito  <= digito_n;
            valido  <= valido_n;
            bcnt    <= bcnt_n;
            fase    <= fase_n;
            ecnt    <= ecnt_n;
            display <= seg_n ^ POLARIDADE;
        end
    end

endmodule

// File: tb/tb_display_quadrante_pisca.sv
// tb/tb_display_quadrante_pisca.sv - self-checking bench for display_quadrante_pisca
module tb_display_quadrante_pisca;

    localparam int NQ = 9;
    localparam int BC = 4;
    localparam int EC = 8;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic          clock = 1'b0;
    logic          reset, limpa, carrega, pisca_en, apaga;
    logic [NQ-1:0] quadrante;
    logic [6:0]    display, display_hi;
    logic [3:0]    digito, digito_hi;
    logic          valido, valido_hi, erro, erro_hi;

    int vectors     = 0;
    int miscompares = 0;

    int         m_mode;   // 0 empty, 1 showing digit, 2 error
    int         m_dig, m_val, m_err_left, m_age;
    logic [6:0] m_disp;

    always #5 clock = ~clock;

    display_quadrante_pisca #(
        .N_QUAD(NQ), .BLINK_CYCLES(BC), .ERR_CYCLES(EC), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .limpa(limpa), .carrega(carrega),
        .quadrante(quadrante), .pisca_en(pisca_en), .apaga(apaga),
        .display(display), .digito(digito), .valido(valido), .erro(erro)
    );

    display_quadrante_pisca #(
        .N_QUAD(NQ), .BLINK_CYCLES(BC), .ERR_CYCLES(EC), .SEG_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .clock(clock), .reset(reset), .limpa(limpa), .carrega(carrega),
        .quadrante(quadrante), .pisca_en(pisca_en), .apaga(apaga),
        .display(display_hi), .digito(digito_hi), .valido(valido_hi), .erro(erro_hi)
    );

    function automatic logic [6:0] glyph_of(input int d);
        case (d)
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    // Reference: error measured as cycles left, blink phase derived from age since last load
    task automatic model_update();
        bit on;
        if (reset || limpa) begin
            m_mode = 0; m_dig = 0; m_val = 0; m_err_left = 0; m_age = 0;
        end else if (carrega) begin
            if ($countones(quadrante) == 1) begin
                for (int i = 0; i < NQ; i++) if (quadrante[i]) m_dig = i + 1;
                m_val  = 1;
                m_mode = 1;
            end else begin
                m_mode     = 2;
                m_err_left = EC;
            end
            m_age = 0;
        end else begin
            m_age++;
            if (m_mode == 2) begin
                m_err_left--;
                if (m_err_left == 0) m_mode = (m_val != 0) ? 1 : 0;
            end
        end
        on = ((m_age / BC) % 2) == 0;
        if (reset || limpa)                     m_disp = DASH;
        else if (apaga)                         m_disp = BLANK;
        else if (m_mode == 2 && !on)            m_disp = BLANK;
        else if (m_mode == 1 && pisca_en && !on) m_disp = BLANK;
        else if (m_mode == 1)                   m_disp = glyph_of(m_dig);
        else                                    m_disp = DASH;
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        limpa = 0; carrega = 0; quadrante = '0; pisca_en = 0; apaga = 0;
    endtask

    task automatic test_reset();
        logic [12:0] got, exp;
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            got = {display, digito, valido, erro};
            exp = {DASH, 4'd0, 1'b0, 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", k, got, exp);
            end
        end
        vectors++;
        if (display_hi !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_active_high: got %b want 1000000", display_hi);
        end
    endtask

    task automatic test_load_blink();
        logic [6:0] exp;
        pisca_en = 1;
        carrega = 1; quadrante = 9'b000010000;
        step();
        carrega = 0; quadrante = '0;
        vectors++;
        if ({display, digito, valido} !== {7'b0010010, 4'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL load5: got %b/%0d/%b want 0010010/5/1", display, digito, valido);
        end
        for (int k = 1; k < 16; k++) begin
            step();
            exp = ((k / BC) % 2 == 0) ? 7'b0010010 : BLANK;
            vectors++;
            if (display !== exp) begin
                miscompares++;
                $display("FAIL blink5 cyc %0d: got %b want %b", k, display, exp);
            end
        end
        pisca_en = 0;
    endtask

    task automatic run_invalid(input string tag, input logic [6:0] final_disp, input logic [3:0] final_dig);
        logic [6:0] exp_d;
        logic       exp_e;
        carrega = 1; quadrante = 9'b000000011;
        step();
        carrega = 0; quadrante = '0;
        for (int k = 0; k <= EC; k++) begin
            if (k > 0) step();
            exp_e = (k < EC);
            exp_d = (k == EC) ? final_disp : (((k / BC) % 2 == 0) ? DASH : BLANK);
            vectors++;
            if ({erro, display} !== {exp_e, exp_d}) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got erro=%b disp=%b want erro=%b disp=%b", tag, k, erro, display, exp_e, exp_d);
            end
        end
        vectors++;
        if (digito !== final_dig) begin
            miscompares++;
            $display("FAIL %s digito: got %0d want %0d", tag, digito, final_dig);
        end
    endtask

    task automatic test_erro_return();
        run_invalid("erro_to_mostra", 7'b0010010, 4'd5);
        reset = 1; step(); reset = 0;
        run_invalid("erro_to_vazio", DASH, 4'd0);
    endtask

    task automatic test_erro_reload();
        carrega = 1; quadrante = 9'b000000011;
        step();
        carrega = 0; quadrante = '0;
        for (int k = 0; k < 4; k++) step();
        carrega = 1; quadrante = 9'b100000000;
        step();
        carrega = 0; quadrante = '0;
        vectors++;
        if ({display, erro, digito} !== {7'b0010000, 1'b0, 4'd9}) begin
            miscompares++;
            $display("FAIL erro_reload: got %b/%b/%0d want 0010000/0/9", display, erro, digito);
        end
    endtask

    task automatic test_limpa_apaga();
        limpa = 1; carrega = 1; quadrante = 9'b000010000;
        step();
        limpa = 0; carrega = 0; quadrante = '0;
        vectors++;
        if ({digito, valido, display} !== {4'd0, 1'b0, DASH}) begin
            miscompares++;
            $display("FAIL limpa_priority: got %0d/%b/%b want 0/0/%b", digito, valido, display, DASH);
        end
        carrega = 1; quadrante = 9'b000000100;
        step();
        carrega = 0; quadrante = '0;
        apaga = 1;
        step();
        vectors++;
        if (display !== BLANK) begin
            miscompares++;
            $display("FAIL apaga_on: got %b want %b", display, BLANK);
        end
        apaga = 0;
        step();
        vectors++;
        if (display !== 7'b0110000) begin
            miscompares++;
            $display("FAIL apaga_off: got %b want 0110000", display);
        end
        carrega = 1; quadrante = 9'b000000001;
        step();
        carrega = 0; quadrante = '0;
        vectors++;
        if ({display_hi, display} !== {7'b0000110, 7'b1111001}) begin
            miscompares++;
            $display("FAIL digit1_polarity: got hi=%b lo=%b want hi=0000110 lo=1111001", display_hi, display);
        end
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            limpa    = ($urandom_range(0, 99) == 0);
            carrega  = ($urandom_range(0, 5) == 0);
            apaga    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) pisca_en = ~pisca_en;
            case ($urandom_range(0, 3))
                0:       quadrante = '0;
                1:       quadrante = NQ'($urandom);
                default: quadrante = NQ'(1) << $urandom_range(0, NQ - 1);
            endcase
            step();
            got = {display, display_hi, digito, valido, erro};
            exp = {m_disp, ~m_disp, 4'(m_dig), m_val != 0, m_mode == 2};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b want %b", n, got, exp);
            end
            vectors++;
            if ({digito_hi, valido_hi, erro_hi} !== {4'(m_dig), m_val != 0, m_mode == 2}) begin
                miscompares++;
                $display("FAIL random_hi cyc %0d: got %0d/%b/%b want %0d/%0d/%0d", n, digito_hi, valido_hi, erro_hi, m_dig, m_val, m_mode == 2);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_load_blink();
        test_erro_return();
        reset = 1; step(); reset = 0;
        test_erro_reload();
        test_limpa_apaga();
        idle_inputs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
